dot_product_engine: RTL
=======================

// Module: dot_product_engine
// PURPOSE
//   Parametrised sequential dot-product core: holds two N-element vectors A and B
//   of DW-bit elements, computes sum(A[i]*B[i]) with one MAC per clock, and reports
//   the result with a busy/done handshake. Sits between the switch/command decoder
//   and the LED/7-segment display logic; generalises the fixed 4x8-bit unit.
// PARAMETERS
//   N   4  vector length, elements per vector (N >= 2)
//   DW  8  element width in bits
//   localparam IW = $clog2(N) (index width); RW = 2*DW + IW (result width)
// PORTS
//   clk          in   1   system clock, rising edge
//   btnc         in   1   asynchronous active-high reset
//   wr_en        in   1   write strobe for one vector element
//   wr_sel       in   1   0 = write A, 1 = write B
//   wr_idx       in   IW  element index
//   wr_data      in   DW  element value
//   clr          in   1   zero both vectors (single-cycle pulse)
//   signed_mode  in   1   1 = two's-complement elements (see CONFIGURATION)
//   start        in   1   begin computation (single-cycle pulse)
//   busy         out  1   computation in progress
//   done         out  1   one-cycle pulse, result updated
//   result       out  RW  last completed dot product
// BEHAVIOUR
//   - Reset (btnc high, async): state IDLE, A/B all zero, acc 0, index 0,
//     busy 0, done 0, result 0. Reset mid-run aborts; result reads 0, no done.
//   - States: IDLE, RUN. IDLE --start--> RUN; RUN --last element--> IDLE.
//   - Start sampled high at edge t0 in IDLE: acc <= 0, idx <= 0, busy <= 1.
//     Edges t1..tN accumulate A[idx]*B[idx] for idx = 0..N-1.
//     At edge tN: result <= final sum, done <= 1, busy <= 0, state <= IDLE.
//     done clears at edge tN+1. Latency start-edge to done = N clocks.
//   - Back-to-back: start may be asserted in the cycle done is high; accepted.
//   - start while busy: ignored (no restart, no queueing).
//   - wr_en / clr while busy: ignored; vectors stay frozen for the whole run.
//   - wr_en with wr_idx >= N (N not a power of two): ignored.
//   - clr and wr_en same cycle in IDLE: clr wins, vectors all zero.
//   - wr_en and start same cycle in IDLE: write commits at t0, run uses new value.
//   - Arithmetic: products 2*DW bits, accumulator RW bits; cannot overflow for
//     unsigned or signed operands. Unsigned: zero-extend. Signed: sign-extend
//     products to RW, result two's complement.
//   - result holds its value until the next completed run or reset.
// CONFIGURATION
//   DP_SIGNED_EN defined: signed_mode honoured, sampled at start edge t0 and held
//     for the run (mid-run changes have no effect).
//   DP_SIGNED_EN undefined: signed_mode ignored, all arithmetic unsigned; no
//     sign-extension logic synthesised.
// TESTING (N=4, DW=8, RW=18)
//   1. Hold btnc 5 us, release -> busy=0, done=0, result=0; start with vectors
//      zero -> done after 4 clks, result=0.
//   2. Write A[0..3]=B[0..3]=2, pulse start -> busy 4 clks, done 1 clk,
//      result=16 (0x00010).
//   3. Write A=B=0xFF all elements, signed_mode=0 -> result=260100 (0x3F804).
//   4. DP_SIGNED_EN defined, same data, signed_mode=1 -> result=4;
//      macro undefined, signed_mode=1 -> result=260100.
//   5. During run: wr_en A[0]=0, second start, clr -> all ignored, result=16;
//      next run still gives 16.
//   6. Assert btnc at t2 of a run -> busy=0, result=0, no done pulse; new run
//      after release yields 0 (vectors cleared by reset).

Source files
------------

// File: rtl/dot_product_engine_if.sv
//------------------------------------------------------------------------------
// Module   : dot_product_engine_if
// Brief    : Command/status bundle between the command decoder and the
//            dot-product core (vector writes, start, busy/done, result).
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

interface dot_product_engine_if #(
   parameter int N  = 4,
   parameter int DW = 8
);
   localparam int IW = $clog2(N);
   localparam int RW = 2 * DW + IW;

   logic          wr_en;
   logic          wr_sel;
   logic [IW-1:0] wr_idx;
   logic [DW-1:0] wr_data;
   logic          clr;
   logic          signed_mode;
   logic          start;
   logic          busy;
   logic          done;
   logic [RW-1:0] result;

   modport master (
      output wr_en, wr_sel, wr_idx, wr_data, clr, signed_mode, start,
      input  busy, done, result
   );

   modport slave (
      input  wr_en, wr_sel, wr_idx, wr_data, clr, signed_mode, start,
      output busy, done, result
   );
endinterface

`default_nettype wire

// File: rtl/dot_product_engine.sv
//------------------------------------------------------------------------------
// Module   : dot_product_engine
// Brief    : Sequential N-element dot product, one MAC per clock, busy/done
//            handshake. Define DP_SIGNED_EN to honour signed_mode.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module dot_product_engine #(
   parameter int N  = 4,
   parameter int DW = 8
) (
   input  wire logic             clk,
   input  wire logic             btnc,
   dot_product_engine_if.slave   dp
);
   localparam int IW = $clog2(N);
   localparam int RW = 2 * DW + IW;
   localparam logic [IW-1:0] LAST_IDX = IW'(N - 1);

   typedef enum logic [0:0] {
      IDLE = 1'b0,
      RUN  = 1'b1
   } state_t;

   state_t          state_q, state_d;
   logic [DW-1:0]   a_q [N];
   logic [DW-1:0]   a_d [N];
   logic [DW-1:0]   b_q [N];
   logic [DW-1:0]   b_d [N];
   logic [RW-1:0]   acc_q, acc_d;
   logic [RW-1:0]   result_q, result_d;
   logic [IW-1:0]   idx_q, idx_d;
   logic            busy_q, busy_d;
   logic            done_q, done_d;
   logic            idx_ok;
   logic [2*DW-1:0] prod;
   logic [RW-1:0]   prod_ext;

`ifdef DP_SIGNED_EN
   logic            sgn_q, sgn_d;
`else
   logic            unused_signed_mode;
   assign unused_signed_mode = dp.signed_mode;
`endif

   // Low 2*DW bits of the product of sign-extended operands equal the signed product.
   always_comb begin
      prod     = {{DW{1'b0}}, a_q[idx_q]} * {{DW{1'b0}}, b_q[idx_q]};
      prod_ext = {{IW{1'b0}}, prod};
`ifdef DP_SIGNED_EN
      if (sgn_q) begin
         prod     = {{DW{a_q[idx_q][DW-1]}}, a_q[idx_q]} *
                    {{DW{b_q[idx_q][DW-1]}}, b_q[idx_q]};
         prod_ext = {{IW{prod[2*DW-1]}}, prod};
      end
`endif
   end

   always_comb begin
      state_d  = state_q;
      a_d      = a_q;
      b_d      = b_q;
      acc_d    = acc_q;
      result_d = result_q;
      idx_d    = idx_q;
      busy_d   = busy_q;
      done_d   = 1'b0;
      idx_ok   = (int'(dp.wr_idx) < N);
`ifdef DP_SIGNED_EN
      sgn_d    = sgn_q;
`endif
      case (state_q)
         IDLE: begin
            if (dp.clr) begin
               a_d = '{default: '0};
               b_d = '{default: '0};
            end else if (dp.wr_en && idx_ok) begin
               if (dp.wr_sel) b_d[dp.wr_idx] = dp.wr_data;
               else           a_d[dp.wr_idx] = dp.wr_data;
            end
            if (dp.start) begin
               state_d = RUN;
               acc_d   = '0;
               idx_d   = '0;
               busy_d  = 1'b1;
`ifdef DP_SIGNED_EN
               sgn_d   = dp.signed_mode;
`endif
            end
         end
         RUN: begin
            acc_d = acc_q + prod_ext;
            if (idx_q == LAST_IDX) begin
               result_d = acc_d;
               done_d   = 1'b1;
               busy_d   = 1'b0;
               state_d  = IDLE;
            end else begin
               idx_d = idx_q + 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge btnc) begin
      if (btnc) begin
         state_q  <= IDLE;
         a_q      <= '{default: '0};
         b_q      <= '{default: '0};
         acc_q    <= '0;
         result_q <= '0;
         idx_q    <= '0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
`ifdef DP_SIGNED_EN
         sgn_q    <= 1'b0;
`endif
      end else begin
         state_q  <= state_d;
         a_q      <= a_d;
         b_q      <= b_d;
         acc_q    <= acc_d;
         result_q <= result_d;
         idx_q    <= idx_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
`ifdef DP_SIGNED_EN
         sgn_q    <= sgn_d;
`endif
      end
   end

   assign dp.busy   = busy_q;
   assign dp.done   = done_q;
   assign dp.result = result_q;

endmodule

`default_nettype wire
